// File: rtl/alu_rf_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_rf_seq_if
// Description : Command/result bundle for alu_rf_seq. The master side issues
//               commands and observes results; the slave side is the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_rf_seq_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [WIDTH-1:0] imm;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, rd, rs1, rs2, imm,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, rd, rs1, rs2, imm,
    output in_ready, out_valid, result, flags
  );
endinterface
`default_nettype wire

// File: rtl/alu_rf_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_rf_seq
// Description : Register-file ALU. Single-cycle ADD/SUB/logic/shift/LOADI and
//               a multi-cycle unsigned shift-add multiplier. Flags {Z,N,C,V}.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rf_seq #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_rf_seq_if.slave bus
);

  localparam int AW   = $clog2(NREGS);
  localparam int AW_S = $clog2(WIDTH);
  localparam int CW   = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  // Counter value seen on the last multiply step (steps are numbered from 0)
  localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] c_OP_ADD   = 3'b000;
  localparam logic [2:0] c_OP_SUB   = 3'b001;
  localparam logic [2:0] c_OP_AND   = 3'b010;
  localparam logic [2:0] c_OP_OR    = 3'b011;
  localparam logic [2:0] c_OP_XOR   = 3'b100;
  localparam logic [2:0] c_OP_SHR   = 3'b101;
  localparam logic [2:0] c_OP_LOADI = 3'b110;
  localparam logic [2:0] c_OP_MUL   = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic [WIDTH-1:0]   r_rf [NREGS];
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [AW-1:0]      r_mul_rd;

  logic               w_accept;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c;
  logic               w_alu_v;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [WIDTH-1:0]   w_mul_hi;

  assign w_accept      = bus.in_valid & r_in_ready;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

  // Operand read; r0 is hard-wired to zero regardless of storage contents
  always_comb begin
    w_a = '0;
    w_b = '0;
    if (bus.rs1 != '0) w_a = r_rf[bus.rs1];
    if (bus.rs2 != '0) w_b = r_rf[bus.rs2];
  end

  // Single-cycle datapath: result plus carry/borrow and signed overflow
  always_comb begin
    w_sum     = {1'b0, w_a} + {1'b0, w_b};
    w_diff    = {1'b0, w_a} - {1'b0, w_b};
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (bus.op)
      c_OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (w_a[MSB] == w_b[MSB]) && (w_alu_res[MSB] != w_a[MSB]);
      end
      c_OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        // Top bit of the widened difference is the unsigned borrow
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (w_a[MSB] != w_b[MSB]) && (w_alu_res[MSB] != w_a[MSB]);
      end
      c_OP_AND:   w_alu_res = w_a & w_b;
      c_OP_OR:    w_alu_res = w_a | w_b;
      c_OP_XOR:   w_alu_res = w_a ^ w_b;
      c_OP_SHR:   w_alu_res = w_a >> w_b[AW_S-1:0];
      c_OP_LOADI: w_alu_res = bus.imm;
      default:    w_alu_res = '0;
    endcase
  end

  // Next partial product: add the shifted multiplicand when the current
  // multiplier LSB is set; the final step's value is the full product
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_lo    = w_prod_next[WIDTH-1:0];
  assign w_mul_hi    = w_prod_next[2*WIDTH-1:WIDTH];

  // Control FSM, register file, multiplier state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_mplier    <= '0;
      r_mul_rd    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.op == c_OP_MUL) begin
              r_state    <= S_MUL;
              r_in_ready <= 1'b0;
              r_cnt      <= '0;
              r_mcand    <= {{WIDTH{1'b0}}, w_a};
              r_mplier   <= w_b;
              r_prod     <= '0;
              r_mul_rd   <= bus.rd;
            end else begin
              r_result    <= w_alu_res;
              r_flags     <= {(w_alu_res == '0), w_alu_res[MSB], w_alu_c, w_alu_v};
              r_out_valid <= 1'b1;
              if (bus.rd != '0) r_rf[bus.rd] <= w_alu_res;
            end
          end
        end
        S_MUL: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == c_CNT_LAST) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b1;
            r_result    <= w_mul_lo;
            r_flags     <= {(w_mul_lo == '0), w_mul_lo[MSB], (w_mul_hi != '0), 1'b0};
            if (r_mul_rd != '0) r_rf[r_mul_rd] <= w_mul_lo;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_rf_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rf_seq
// Description : Self-checking bench for alu_rf_seq (WIDTH=8, NREGS=4):
//               directed scenarios followed by random commands compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rf_seq;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  localparam logic [2:0] c_ADD = 3'd0, c_SUB = 3'd1, c_AND = 3'd2, c_OR = 3'd3;
  localparam logic [2:0] c_XOR = 3'd4, c_SHR = 3'd5, c_LDI = 3'd6, c_MUL = 3'd7;

  logic clk;
  logic rst;

  alu_rf_seq_if #(.WIDTH(W), .NREGS(N)) bus ();

  alu_rf_seq #(.WIDTH(W), .NREGS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference architectural state
  int         m_rf [N];
  logic [7:0] m_res;
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int to_signed(input int x);
    return (x >= HALF) ? x - (1 << W) : x;
  endfunction

  // Returns {Z,N,C,V,result[7:0]} from plain integer arithmetic
  function automatic logic [11:0] ref_op(input logic [2:0] op, input int a, input int b, input int imm);
    int  res, c, v, ss;
    longint p;
    c = 0;
    v = 0;
    case (op)
      c_ADD: begin
        res = a + b;
        c   = (res > MASK) ? 1 : 0;
        ss  = to_signed(a) + to_signed(b);
        v   = (ss > HALF - 1 || ss < -HALF) ? 1 : 0;
      end
      c_SUB: begin
        res = a - b;
        c   = (a < b) ? 1 : 0;
        ss  = to_signed(a) - to_signed(b);
        v   = (ss > HALF - 1 || ss < -HALF) ? 1 : 0;
      end
      c_AND: res = a & b;
      c_OR:  res = a | b;
      c_XOR: res = a ^ b;
      c_SHR: res = a >> (b % W);
      c_LDI: res = imm;
      default: begin
        p   = longint'(a) * longint'(b);
        res = int'(p & MASK);
        c   = ((p >> W) != 0) ? 1 : 0;
      end
    endcase
    res = res & MASK;
    return {(res == 0), (res >= HALF), c[0], v[0], 8'(res)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_rf[i] = 0;
    m_res   = '0;
    m_flags = '0;
  endtask

  // Issue one command in an idle cycle and check its completion; during a
  // multiply, optionally keep in_valid high with junk fields.
  task automatic issue(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                       input int imm, input bit junk);
    logic [11:0] e;
    e = ref_op(op, m_rf[rs1], m_rf[rs2], imm);
    check_eq("ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.rd       = 2'(rd);
    bus.rs1      = 2'(rs1);
    bus.rs2      = 2'(rs2);
    bus.imm      = 8'(imm);
    step();
    if (op == c_MUL) begin
      for (int i = 1; i <= W; i++) begin
        bus.in_valid = junk;
        bus.op       = 3'($urandom);
        bus.rd       = 2'($urandom);
        bus.rs1      = 2'($urandom);
        bus.rs2      = 2'($urandom);
        bus.imm      = 8'($urandom);
        check_eq("mul_busy_ready", bus.in_ready, 0);
        check_eq("mul_busy_ov", bus.out_valid, 0);
        step();
      end
    end
    bus.in_valid = 1'b0;
    check_eq("done_ov", bus.out_valid, 1);
    check_eq("done_result", bus.result, e[7:0]);
    check_eq("done_flags", bus.flags, e[11:8]);
    if (rd != 0) m_rf[rd] = int'(e[7:0]);
    m_res   = e[7:0];
    m_flags = e[11:8];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b0;
      step();
      check_eq("idle_ov", bus.out_valid, 0);
      check_eq("idle_ready", bus.in_ready, 1);
      check_eq("idle_result", bus.result, m_res);
      check_eq("idle_flags", bus.flags, m_flags);
    end
  endtask

  // Assert reset mid-cycle; outputs must clear without waiting for a clock
  task automatic reset_mid(input string tag);
    #2 rst = 1'b1;
    #1;
    check_eq({tag, "_ready"}, bus.in_ready, 1);
    check_eq({tag, "_ov"}, bus.out_valid, 0);
    check_eq({tag, "_result"}, bus.result, 0);
    check_eq({tag, "_flags"}, bus.flags, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  initial begin
    clk          = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.rd       = '0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.imm      = '0;
    model_clear();

    step();
    step();
    check_eq("rst_ready", bus.in_ready, 1);
    check_eq("rst_ov", bus.out_valid, 0);
    check_eq("rst_result", bus.result, 0);
    check_eq("rst_flags", bus.flags, 0);
    rst = 1'b0;

    // Signed overflow into bit 7, accepted on the first edge out of reset
    issue(c_LDI, 1, 0, 0, 8'h7F, 0);
    issue(c_LDI, 2, 0, 0, 8'h01, 0);
    issue(c_ADD, 3, 1, 2, 0, 0);
    check_eq("add_ovf_result", bus.result, 8'h80);
    check_eq("add_ovf_flags", bus.flags, 4'b0101);

    // Borrow on subtract, then a logical shift
    issue(c_SUB, 3, 2, 1, 0, 0);
    check_eq("sub_borrow_result", bus.result, 8'h82);
    check_eq("sub_borrow_flags", bus.flags, 4'b0110);
    issue(c_SHR, 3, 1, 2, 0, 0);
    check_eq("shr_result", bus.result, 8'h3F);
    idle(2);

    // Multiply with product overflowing into the upper half
    issue(c_LDI, 1, 0, 0, 8'h10, 0);
    issue(c_LDI, 2, 0, 0, 8'h20, 0);
    issue(c_MUL, 3, 1, 2, 0, 1);
    check_eq("mul_result", bus.result, 8'h00);
    check_eq("mul_flags", bus.flags, 4'b1010);
    idle(1);

    // Read-after-write with no gap, and r0 write discard
    issue(c_LDI, 1, 0, 0, 8'h05, 0);
    issue(c_ADD, 2, 1, 1, 0, 0);
    check_eq("raw_result", bus.result, 8'h0A);
    issue(c_LDI, 0, 0, 0, 8'hFF, 0);
    issue(c_OR, 1, 0, 0, 0, 0);
    check_eq("r0_result", bus.result, 8'h00);
    check_eq("r0_flags", bus.flags, 4'b1000);
    idle(1);

    // Reset during the third multiply cycle aborts the multiply
    issue(c_LDI, 1, 0, 0, 8'h10, 0);
    issue(c_LDI, 2, 0, 0, 8'h20, 0);
    issue(c_LDI, 3, 0, 0, 8'h55, 0);
    bus.in_valid = 1'b1;
    bus.op       = c_MUL;
    bus.rd       = 2'd3;
    bus.rs1      = 2'd1;
    bus.rs2      = 2'd2;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check_eq("abort_busy", bus.in_ready, 0);
    reset_mid("abort");
    idle(12);
    issue(c_OR, 1, 3, 0, 0, 0);
    check_eq("abort_rd_cleared", bus.result, 8'h00);

    // Reset in an ordinary idle stretch, then OR over cleared registers
    issue(c_LDI, 1, 0, 0, 8'hA5, 0);
    issue(c_LDI, 2, 0, 0, 8'h3C, 0);
    idle(1);
    reset_mid("midrst");
    issue(c_OR, 1, 1, 2, 0, 0);
    check_eq("midrst_or_result", bus.result, 8'h00);
    check_eq("midrst_or_z", bus.flags[3], 1);

    // Random commands against the reference model
    for (int k = 0; k < 120; k++) begin
      issue(3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
